// File: rtl/svm_mem_pkg.sv
// Shared RAM geometry, reader FSM states and stall-counter width for the SVM memory path.
// Optional stall counter in the reader is enabled by BRAM_RD_STALL_CNT_EN.
package svm_mem_pkg;

  localparam int RAM_ADDR_WIDTH = 10;
  localparam int RAM_DATA_WIDTH = 8;
  localparam int STALL_CNT_W    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/sync_fifo2.sv
// Purpose: 2-entry first-word-fall-through FIFO carrying a data word and a last flag.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internal; the producer must not push into a full FIFO.
module sync_fifo2
  import svm_mem_pkg::*;
#(
  parameter int DATA_WIDTH = RAM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  input  logic                  pop,
  output logic [1:0]            count,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_last
);

  logic [DATA_WIDTH-1:0] tail_data;
  logic                  tail_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count     <= 2'd0;
      head_data <= '0;
      head_last <= 1'b0;
      tail_data <= '0;
      tail_last <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_data <= push_data;
            head_last <= push_last;
          end else begin
            tail_data <= push_data;
            tail_last <= push_last;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_data <= tail_data;
          head_last <= tail_last;
          count     <= count - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop keeps the count; the new word lands behind any survivor.
          if (count == 2'd1) begin
            head_data <= push_data;
            head_last <= push_last;
          end else begin
            head_data <= tail_data;
            head_last <= tail_last;
            tail_data <= push_data;
            tail_last <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Purpose: reads len words from base_addr out of the block RAM and streams them with valid/ready.
// Latency: start at T -> ram_re at T+1 -> m_valid at T+3; then one word per cycle.
// Backpressure: m_ready low throttles reads via a 2-entry FIFO; optional stall_cnt (BRAM_RD_STALL_CNT_EN).
module bram_stream_reader
  import svm_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [LEN_WIDTH-1:0]   len,
  output logic                   busy,
  output logic                   done,
  output logic                   ram_re,
  output logic [ADDR_WIDTH-1:0]  ram_addr,
  input  logic [DATA_WIDTH-1:0]  ram_do,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  output logic                   m_last,
  input  logic                   m_ready
`ifdef BRAM_RD_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  rd_state_e            state;
  logic [LEN_WIDTH-1:0] rem;
  logic                 inflight;
  logic                 inflight_last;
  logic [1:0]           fifo_count;
  logic [2:0]           occ;
  logic                 pop;
  logic                 rd_last;
  logic                 drain_exit;

  sync_fifo2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (ram_do),
    .push_last (inflight_last),
    .pop       (pop),
    .count     (fifo_count),
    .head_data (m_data),
    .head_last (m_last)
  );

  assign m_valid = (fifo_count != 2'd0);
  assign pop     = m_valid & m_ready;
  assign occ     = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  // ram_re uses this cycle's pop so a full-rate stream keeps issuing one read per cycle.
  assign ram_re  = (state == READ) && (occ < 3'd2);
  assign rd_last = (rem == LEN_WIDTH'(1));
  assign drain_exit = !inflight &&
                      ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      ram_addr      <= '0;
      rem           <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= ram_re;
      inflight_last <= ram_re & rd_last;
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            ram_addr <= base_addr;
            rem      <= len;
            busy     <= 1'b1;
            state    <= (len == '0) ? DONE : READ;
          end
        end
        READ: begin
          if (ram_re) begin
            ram_addr <= ram_addr + 1'b1;
            rem      <= rem - 1'b1;
            if (rd_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_exit) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          // Arriving from DRAIN the pulse is already up; a zero-length run raises it here.
          done  <= ~done;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BRAM_RD_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      stall_cnt <= '0;
    end else if (m_valid && !m_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Testbench for bram_stream_reader: behavioural RAM, per-run expected word list, stream monitor.
// Build with +define+BRAM_RD_STALL_CNT_EN to also cover stall_cnt.
module tb_bram_stream_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] len;
  logic        busy;
  logic        done;
  logic        ram_re;
  logic [9:0]  ram_addr;
  logic [7:0]  ram_do;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;
`ifdef BRAM_RD_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  bram_stream_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .ram_re    (ram_re),
    .ram_addr  (ram_addr),
    .ram_do    (ram_do),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready)
`ifdef BRAM_RD_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] mem [1024];

  // monitor state
  logic       mon_en = 1'b0;
  logic [7:0] data_q [$];
  logic       last_q [$];
  int         addr_q [$];
  int         first_re, first_vld, last_xfer, done_cyc, done_cnt, stalls;
  logic       stall_prev;
  logic [7:0] prev_data;
  logic       prev_last;
  int         rdy_mode = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAM with one cycle of latency.
  always @(posedge clk) if (ram_re) ram_do <= mem[ram_addr];

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: m_ready = 1'b1;
        1: m_ready = ((cyc % 6) == 0) || ((cyc % 6) == 3) || ((cyc % 6) == 5);
        2: m_ready = ($urandom_range(0, 99) < 60);
        default: m_ready = 1'b0;
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (ram_re) begin
          addr_q.push_back(int'(ram_addr));
          if (first_re < 0) first_re = cyc;
        end
        if (m_valid && first_vld < 0) first_vld = cyc;
        if (stall_prev) begin
          check("hold_valid", m_valid, 1);
          check("hold_data", m_data, prev_data);
          check("hold_last", m_last, prev_last);
        end
        if (m_valid && m_ready) begin
          data_q.push_back(m_data);
          last_q.push_back(m_last);
          last_xfer = cyc;
        end
        if (m_valid && !m_ready) stalls++;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          check("busy_at_done", busy, 0);
        end
        stall_prev = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
      end
    end
  end

  task automatic clear_mon();
    data_q.delete();
    last_q.delete();
    addr_q.delete();
    first_re   = -1;
    first_vld  = -1;
    last_xfer  = -1;
    done_cyc   = -1;
    done_cnt   = 0;
    stalls     = 0;
    stall_prev = 1'b0;
  endtask

  task automatic run(input int base, input int length, input int mode);
    int t0;
    int budget;
    clear_mon();
    rdy_mode = mode;
    @(posedge clk);
    #1;
    base_addr = base[9:0];
    len       = length[10:0];
    start     = 1'b1;
    t0        = cyc;
    mon_en    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_rise", busy, 1);
    budget = 8 * length + 40;
    while (done_cnt == 0 && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    check("done_seen", done_cnt > 0, 1);
    repeat (3) begin
      @(negedge clk);
      #1;
    end
    mon_en = 1'b0;
    check("done_once", done_cnt, 1);
    check("busy_after", busy, 0);
    check("nwords", data_q.size(), length);
    check("nreads", addr_q.size(), length);
    for (int i = 0; i < length && i < data_q.size(); i++) begin
      check("word", data_q[i], mem[(base + i) % 1024]);
      check("last", last_q[i], (i == length - 1) ? 1 : 0);
    end
    for (int i = 0; i < length && i < addr_q.size(); i++)
      check("addr", addr_q[i], (base + i) % 1024);
    if (length > 0) begin
      check("lat_re", first_re - t0, 1);
      check("lat_valid", first_vld - t0, 3);
      check("done_after_last", done_cyc - last_xfer, 1);
      if (mode == 0) check("full_rate", last_xfer - first_vld, length - 1);
    end else begin
      check("zero_no_re", first_re, -1);
      check("zero_no_valid", first_vld, -1);
      check("zero_done_lat", done_cyc - t0, 2);
    end
`ifdef BRAM_RD_STALL_CNT_EN
    check("stall_cnt", stall_cnt, stalls);
`endif
  endtask

  initial begin
    int budget;
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom_range(0, 255));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_re", ram_re, 0);
    check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_data", m_data, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    mem[1] = 8'hF0; mem[2] = 8'h11; mem[3] = 8'h22; mem[4] = 8'h0F;
    run(1, 4, 0);
    run(1, 4, 1);
    mem[1022] = 8'hA0; mem[1023] = 8'hA1; mem[0] = 8'hA2; mem[1] = 8'hA3;
    run(1022, 4, 0);
    run(5, 0, 0);
    run(0, 1024, 0);

    // Abort a run with a stalled word at the output.
    mem[1] = 8'hF0;
    clear_mon();
    rdy_mode = 0;
    @(posedge clk);
    #1;
    base_addr = 10'd1;
    len       = 11'd4;
    start     = 1'b1;
    mon_en    = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    budget = 20;
    while (data_q.size() < 2 && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    check("pre_rst_words", data_q.size() >= 2, 1);
    rdy_mode = 3;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_valid", m_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    rdy_mode = 0;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_valid", m_valid, 0);
      check("post_rst_done", done, 0);
    end
    run(4, 1, 0);

    for (int k = 0; k < 12; k++)
      run($urandom_range(0, 1023), $urandom_range(1, 40), (k % 3 == 0) ? 0 : 2);
    run(1020, 9, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
